// File: rtl/bcd_scan_pkg.sv
// Shared constants for the four-digit BCD counter and its display scan.
package bcd_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BLANK_CODE = 4'b1111;

    // Active-low one-hot digit enables, entry 0 drives the units digit.
    localparam logic [NUM_DIGITS-1:0][3:0] SEL_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts up or down when ci is set, co flags rollover/borrow.
module bcd_digit
    import bcd_scan_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       ci,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] value,
    output logic       co
);

    // co is combinational so a whole 9999 -> 0000 ripple resolves in one edge.
    assign co = ci && (up ? (value == BCD_MAX) : (value == 4'd0));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (ci) begin
            if (up) begin
                value <= (value == BCD_MAX) ? 4'd0 : value + 4'd1;
            end else begin
                value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD event counter with prescaler and a multiplexed,
// leading-zero-blanked digit scan for a 7-segment decoder.
module bcd_scan_counter
    import bcd_scan_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int BLANK_LZ = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        En,
    input  logic        Clr,
    input  logic        Up,
    output logic [15:0] Count,
    output logic        Carry,
    output logic [3:0]  A,
    output logic [3:0]  Sel
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0]      pre;
    logic                  tick;
    logic [NUM_DIGITS:0]   chain;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [1:0]            idx;
    logic [NUM_DIGITS-1:0] dz;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            cur_digit;
    logic [3:0]            a_next;

    assign tick = En && (pre == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pre <= '0;
        end else if (Clr) begin
            pre <= '0;
        end else if (En) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    assign chain[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .ci    (chain[i]),
            .up    (Up),
            .clr   (Clr),
            .value (Count[4*i +: 4]),
            .co    (chain[i+1])
        );
    end

    // Clear wins over a coincident wrap, so its carry is suppressed here.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Carry <= 1'b0;
        end else begin
            Carry <= chain[NUM_DIGITS] && !Clr;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // lz[i]: digit i and every digit above it are zero; units never blanks.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_zero
        assign dz[i] = (Count[4*i +: 4] == 4'd0);
    end
    assign lz = {dz[3], dz[3] & dz[2], dz[3] & dz[2] & dz[1], 1'b0};

    assign cur_digit = Count[{idx, 2'b00} +: 4];
    assign a_next    = ((BLANK_LZ != 0) && lz[idx]) ? BLANK_CODE : cur_digit;

    // Sel and A share one register stage so they always switch together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Sel <= SEL_PATTERN[0];
            A   <= 4'h0;
        end else begin
            Sel <= SEL_PATTERN[idx];
            A   <= a_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: three parameterisations share one stimulus and
// are tracked by an arithmetic model, plus directed literal checks.
module tb_bcd_scan_counter;

    typedef struct {
        int         cnt;
        int         pre;
        int         scan;
        int         idx;
        logic       carry;
        logic [3:0] a;
        logic [3:0] sel;
    } m_t;

    localparam int ND = 3;
    int TD [ND] = '{1, 4, 3};
    int SD [ND] = '{2, 2, 2};
    int BL [ND] = '{1, 0, 1};
    int P10 [4] = '{1, 10, 100, 1000};
    logic [3:0] SEL_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic up = 1'b1;

    logic [15:0] cnt_o   [ND];
    logic        carry_o [ND];
    logic [3:0]  a_o     [ND];
    logic [3:0]  sel_o   [ND];

    m_t m [ND];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_scan_counter #(.TICK_DIV(1), .SCAN_DIV(2), .BLANK_LZ(1)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Up(up),
        .Count(cnt_o[0]), .Carry(carry_o[0]), .A(a_o[0]), .Sel(sel_o[0]));
    bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Up(up),
        .Count(cnt_o[1]), .Carry(carry_o[1]), .A(a_o[1]), .Sel(sel_o[1]));
    bcd_scan_counter #(.TICK_DIV(3), .SCAN_DIV(2), .BLANK_LZ(1)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Up(up),
        .Count(cnt_o[2]), .Carry(carry_o[2]), .A(a_o[2]), .Sel(sel_o[2]));

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (v / P10[i]) % 10;
            r[4*i +: 4] = d[3:0];
        end
        return r;
    endfunction

    function automatic m_t reset_m();
        m_t r;
        r.cnt = 0; r.pre = 0; r.scan = 0; r.idx = 0;
        r.carry = 1'b0; r.a = 4'h0; r.sel = 4'b1110;
        return r;
    endfunction

    function automatic m_t next_m(m_t s, int k, logic e, logic c, logic u);
        m_t n;
        int d;
        n = s;
        d = (s.cnt / P10[s.idx]) % 10;
        n.sel = SEL_TAB[s.idx];
        n.a = (BL[k] != 0 && s.idx > 0 && s.cnt < P10[s.idx]) ? 4'hF : d[3:0];
        n.carry = 1'b0;
        n.scan = (s.scan + 1) % SD[k];
        if (s.scan == SD[k] - 1) n.idx = (s.idx + 1) % 4;
        if (c) begin
            n.cnt = 0;
            n.pre = 0;
        end else if (e) begin
            if (s.pre == TD[k] - 1) begin
                n.pre = 0;
                if (u) begin
                    n.carry = (s.cnt == 9999);
                    n.cnt = (s.cnt + 1) % 10000;
                end else begin
                    n.carry = (s.cnt == 0);
                    n.cnt = (s.cnt + 9999) % 10000;
                end
            end else begin
                n.pre = s.pre + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ND; k++) m[k] <= reset_m();
        end else begin
            for (int k = 0; k < ND; k++) m[k] <= next_m(m[k], k, en, clr, up);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare on the falling edge against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < ND; k++) begin
                check($sformatf("dut%0d count", k), int'(cnt_o[k]), int'(to_bcd(m[k].cnt)));
                check($sformatf("dut%0d carry", k), int'(carry_o[k]), int'(m[k].carry));
                check($sformatf("dut%0d a", k), int'(a_o[k]), int'(m[k].a));
                check($sformatf("dut%0d sel", k), int'(sel_o[k]), int'(m[k].sel));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_a;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check("reset count", int'(cnt_o[k]), 0);
            check("reset sel", int'(sel_o[k]), 'b1110);
            check("reset a", int'(a_o[k]), 0);
            check("reset carry", int'(carry_o[k]), 0);
        end
        rst_n = 1'b1;

        // Run to 0456, then reset mid-cycle.
        en = 1'b1; up = 1'b1;
        cyc(456);
        check("run 0456", int'(cnt_o[0]), 'h0456);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async count", int'(cnt_o[0]), 0);
        check("async sel", int'(sel_o[0]), 'b1110);
        check("async a", int'(a_o[0]), 0);
        check("async carry", int'(carry_o[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decade carries and up wrap.
        en = 1'b1; up = 1'b1;
        cyc(9);   check("up 0009", int'(cnt_o[0]), 'h0009);
        cyc(1);   check("up 0010", int'(cnt_o[0]), 'h0010);
                  check("up carry0", int'(carry_o[0]), 0);
        cyc(89);  check("up 0099", int'(cnt_o[0]), 'h0099);
        cyc(1);   check("up 0100", int'(cnt_o[0]), 'h0100);
        cyc(899); check("up 0999", int'(cnt_o[0]), 'h0999);
        cyc(1);   check("up 1000", int'(cnt_o[0]), 'h1000);
                  check("up carry1", int'(carry_o[0]), 0);
        cyc(8999); check("up 9999", int'(cnt_o[0]), 'h9999);
        cyc(1);   check("wrap 0000", int'(cnt_o[0]), 'h0000);
                  check("wrap carry", int'(carry_o[0]), 1);
        cyc(1);   check("post 0001", int'(cnt_o[0]), 'h0001);
                  check("post carry", int'(carry_o[0]), 0);

        // Down wrap.
        up = 1'b0;
        cyc(1);   check("dn 0000", int'(cnt_o[0]), 'h0000);
                  check("dn carry0", int'(carry_o[0]), 0);
        cyc(1);   check("dn 9999", int'(cnt_o[0]), 'h9999);
                  check("dn carry", int'(carry_o[0]), 1);
        cyc(1);   check("dn 9998", int'(cnt_o[0]), 'h9998);
                  check("dn carry1", int'(carry_o[0]), 0);

        // Clear beats a wrapping tick.
        up = 1'b1;
        cyc(1);   check("pre clr 9999", int'(cnt_o[0]), 'h9999);
        clr = 1'b1;
        cyc(1);   check("clr count", int'(cnt_o[0]), 0);
                  check("clr carry", int'(carry_o[0]), 0);
        clr = 1'b0;

        // TICK_DIV=4: clear mid-prescale restarts the 4-cycle step.
        cyc(2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(3);   check("t4 hold", int'(cnt_o[1]), 0);
        cyc(1);   check("t4 step", int'(cnt_o[1]), 1);

        // TICK_DIV=3: prescaler holds while En is low.
        en = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; en = 1'b1;
        cyc(2);
        en = 1'b0;
        cyc(10);  check("t3 hold", int'(cnt_o[2]), 0);
        en = 1'b1;
        cyc(1);   check("t3 step", int'(cnt_o[2]), 1);

        // Scan of 0305 with blanking.
        en = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; en = 1'b1;
        cyc(305);
        en = 1'b0;
        check("scan 0305", int'(cnt_o[0]), 'h0305);
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            case (sel_o[0])
                4'b1110: exp_a = 4'h5;
                4'b1101: exp_a = 4'h0;
                4'b1011: exp_a = 4'h3;
                default: exp_a = 4'hF;
            endcase
            check("scan onehot", $countones(~sel_o[0]), 1);
            check("scan a 0305", int'(a_o[0]), int'(exp_a));
            cyc(1);
        end

        // All-zero display, with and without blanking.
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            exp_a = (sel_o[0] == 4'b1110) ? 4'h0 : 4'hF;
            check("zero blank a", int'(a_o[0]), int'(exp_a));
            check("zero noblank a", int'(a_o[1]), 0);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
